// File: rtl/debug_slave_cmd_bridge_if.sv
// Command handshake between the debug command bridge and the CPU debug logic.
// The bridge presents a head command and one-hot take pulses; the consumer returns ready.
interface debug_slave_cmd_bridge_if #(
  parameter int IR_W = 2,
  parameter int SR_W = 38
);
  localparam int NUM_CMD = 1 << IR_W;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_W-1:0]     cmd_ir;
  logic                cmd_action;
  logic [SR_W-1:0]     jdo;
  logic [NUM_CMD-1:0]  take_action;
  logic [NUM_CMD-1:0]  take_no_action;

  modport master (
    output cmd_valid, cmd_ir, cmd_action, jdo, take_action, take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_action, jdo, take_action, take_no_action,
    output cmd_ready
  );
endinterface

// File: rtl/debug_slave_cmd_bridge.sv
// Sysclk-side bridge for the JTAG debug slave: synchronises update strobes, queues
// captured shift-register commands in a FIFO and hands them out via valid/ready.
module debug_slave_cmd_bridge #(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int ACT_BIT     = 35,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SR_W-1:0]           sr,
  input  logic [IR_W-1:0]           ir_in,
  input  logic                      vs_udr,
  input  logic                      vs_uir,
  input  logic                      ovf_clr,
  debug_slave_cmd_bridge_if.master  cmd,
  output logic                      ir_update,
  output logic [IR_W-1:0]           ir_latched,
  output logic [$clog2(DEPTH):0]    fill,
  output logic                      overflow
);

  localparam int NUM_CMD = 1 << IR_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int FILL_W  = PTR_W + 1;
  localparam int ENT_W   = IR_W + 1 + SR_W;
  localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(DEPTH);

  logic [SYNC_STAGES-1:0] udr_sync_p0, uir_sync_p0;
  logic                   udr_last_p1, uir_last_p1;
  logic                   udr_rise, uir_rise;

  logic [ENT_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr, rd_nxt;
  logic                   full, do_pop, do_push, ovf_evt, head_load;
  logic [ENT_W-1:0]       push_word, head_word;
  logic [NUM_CMD-1:0]     head_onehot;

  // Stage p0: synchroniser chains; stage p1: edge-detect flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_p0 <= '0;
      uir_sync_p0 <= '0;
      udr_last_p1 <= 1'b0;
      uir_last_p1 <= 1'b0;
    end else begin
      udr_sync_p0 <= {udr_sync_p0[SYNC_STAGES-2:0], vs_udr};
      uir_sync_p0 <= {uir_sync_p0[SYNC_STAGES-2:0], vs_uir};
      udr_last_p1 <= udr_sync_p0[SYNC_STAGES-1];
      uir_last_p1 <= uir_sync_p0[SYNC_STAGES-1];
    end
  end

  assign udr_rise = udr_sync_p0[SYNC_STAGES-1] & ~udr_last_p1;
  assign uir_rise = uir_sync_p0[SYNC_STAGES-1] & ~uir_last_p1;

  assign push_word     = {ir_in, sr[ACT_BIT], sr};
  assign cmd.cmd_valid = (fill != '0);
  assign full          = (fill == FULL_CNT);
  assign do_pop        = cmd.cmd_valid & cmd.cmd_ready;
  // A pop frees the slot the push needs, so a full FIFO still accepts a push then.
  assign do_push       = udr_rise & (~full | do_pop);
  assign ovf_evt       = udr_rise & full & ~do_pop;
  assign rd_nxt        = rd_ptr + 1'b1;
  assign head_onehot   = {{(NUM_CMD-1){1'b0}}, 1'b1} << cmd.cmd_ir;

  // Head registers track whatever entry will sit at rd_ptr after this edge.
  always_comb begin
    head_load = 1'b0;
    head_word = push_word;
    if (do_push && (fill == '0 || (do_pop && fill == FILL_W'(1)))) begin
      head_load = 1'b1;
    end else if (do_pop && fill > FILL_W'(1)) begin
      head_load = 1'b1;
      head_word = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  // Stage p2: FIFO control, head outputs and take pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fill               <= '0;
      overflow           <= 1'b0;
      cmd.cmd_ir         <= '0;
      cmd.cmd_action     <= 1'b0;
      cmd.jdo            <= '0;
      cmd.take_action    <= '0;
      cmd.take_no_action <= '0;
      ir_update          <= 1'b0;
      ir_latched         <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      overflow <= ovf_evt | (overflow & ~ovf_clr);
      if (head_load) begin
        cmd.cmd_ir     <= head_word[ENT_W-1 -: IR_W];
        cmd.cmd_action <= head_word[SR_W];
        cmd.jdo        <= head_word[SR_W-1:0];
      end
      cmd.take_action    <= (do_pop &  cmd.cmd_action) ? head_onehot : '0;
      cmd.take_no_action <= (do_pop & ~cmd.cmd_action) ? head_onehot : '0;
      ir_update <= uir_rise;
      if (uir_rise) ir_latched <= ir_in;
    end
  end

endmodule

// File: tb/tb_debug_slave_cmd_bridge.sv
// Bench for debug_slave_cmd_bridge: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the command bridge.
module tb_debug_slave_cmd_bridge;

  localparam int IR_W    = 2;
  localparam int SR_W    = 38;
  localparam int ACT_BIT = 35;
  localparam int DEPTH   = 4;
  localparam int S       = 2;
  localparam int NUM_CMD = 1 << IR_W;
  localparam int ENT_W   = IR_W + 1 + SR_W;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [SR_W-1:0]        sr;
  logic [IR_W-1:0]        ir_in;
  logic                   vs_udr, vs_uir, ovf_clr, cmd_ready;
  logic                   ir_update;
  logic [IR_W-1:0]        ir_latched;
  logic [$clog2(DEPTH):0] fill;
  logic                   overflow;

  always #5 clk = ~clk;

  debug_slave_cmd_bridge_if #(.IR_W(IR_W), .SR_W(SR_W)) cmd ();
  assign cmd.cmd_ready = cmd_ready;

  debug_slave_cmd_bridge #(
    .IR_W(IR_W), .SR_W(SR_W), .ACT_BIT(ACT_BIT), .DEPTH(DEPTH), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .ovf_clr(ovf_clr), .cmd(cmd),
    .ir_update(ir_update), .ir_latched(ir_latched), .fill(fill), .overflow(overflow)
  );

  logic [ENT_W-1:0]   q[$];
  bit                 hist_udr [S+2];
  bit                 hist_uir [S+2];
  logic               m_ovf, m_irup;
  logic [IR_W-1:0]    m_irl;
  logic [NUM_CMD-1:0] m_ta, m_tna;
  int                 n_chk = 0;
  int                 n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    for (int j = 0; j < S + 2; j++) begin
      hist_udr[j] = 1'b0;
      hist_uir[j] = 1'b0;
    end
    m_ovf = 1'b0; m_irup = 1'b0; m_irl = '0; m_ta = '0; m_tna = '0;
  endtask

  task automatic compare_all();
    chk("cmd_valid", 64'(cmd.cmd_valid), 64'(q.size() != 0));
    chk("fill", 64'(fill), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("take_action", 64'(cmd.take_action), 64'(m_ta));
    chk("take_no_action", 64'(cmd.take_no_action), 64'(m_tna));
    chk("ir_update", 64'(ir_update), 64'(m_irup));
    chk("ir_latched", 64'(ir_latched), 64'(m_irl));
    if (q.size() != 0) begin
      chk("cmd_ir", 64'(cmd.cmd_ir), 64'(q[0][ENT_W-1 -: IR_W]));
      chk("cmd_action", 64'(cmd.cmd_action), 64'(q[0][SR_W]));
      chk("jdo", 64'(cmd.jdo), 64'(q[0][SR_W-1:0]));
    end
  endtask

  // One clock: the model applies the rules to the inputs seen at this edge.
  task automatic step();
    bit               udr_rise, uir_rise, pop, ovf_evt;
    logic [ENT_W-1:0] head;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int j = S + 1; j > 0; j--) begin
        hist_udr[j] = hist_udr[j-1];
        hist_uir[j] = hist_uir[j-1];
      end
      hist_udr[0] = vs_udr;
      hist_uir[0] = vs_uir;
      udr_rise = hist_udr[S] && !hist_udr[S+1];
      uir_rise = hist_uir[S] && !hist_uir[S+1];
      pop  = (q.size() != 0) && cmd_ready;
      m_ta = '0;
      m_tna = '0;
      if (pop) begin
        head = q.pop_front();
        if (head[SR_W]) m_ta[head[ENT_W-1 -: IR_W]] = 1'b1;
        else            m_tna[head[ENT_W-1 -: IR_W]] = 1'b1;
      end
      ovf_evt = udr_rise && (q.size() == DEPTH);
      if (udr_rise && !ovf_evt) q.push_back({ir_in, sr[ACT_BIT], sr});
      if (ovf_evt)      m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_irup = uir_rise;
      if (uir_rise) m_irl = ir_in;
    end
    #1;
    compare_all();
  endtask

  // Issue one update-DR strobe with stable data; optionally pop / clear at the push edge.
  task automatic udr_cmd(input logic [IR_W-1:0] ir, input bit act, input bit pop_at_push,
                         input bit clr_at_push);
    ir_in = ir;
    sr = SR_W'({$urandom(), $urandom()});
    sr[ACT_BIT] = act;
    vs_udr = 1'b1;
    for (int i = 0; i <= S; i++) begin
      if (i == 1) vs_udr = 1'b0;
      if (i == S) begin
        cmd_ready = pop_at_push;
        ovf_clr = clr_at_push;
      end
      step();
    end
    cmd_ready = 1'b0;
    ovf_clr = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(cmd.cmd_valid), 64'(0));
    chk({tag, "_fill"}, 64'(fill), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(0));
    chk({tag, "_jdo"}, 64'(cmd.jdo), 64'(0));
    chk({tag, "_ir"}, 64'(cmd.cmd_ir), 64'(0));
    chk({tag, "_act"}, 64'(cmd.cmd_action), 64'(0));
    chk({tag, "_ta"}, 64'(cmd.take_action), 64'(0));
    chk({tag, "_tna"}, 64'(cmd.take_no_action), 64'(0));
    chk({tag, "_irup"}, 64'(ir_update), 64'(0));
    chk({tag, "_irl"}, 64'(ir_latched), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sr = '0; ir_in = '0; vs_udr = 1'b0; vs_uir = 1'b0;
    ovf_clr = 1'b0; cmd_ready = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst0");
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // First command: three-cycle latency, then pop with a take_action pulse
    ir_in = 2'd2;
    sr = 38'h2A_1234_5678;
    vs_udr = 1'b1;
    repeat (S + 1) step();
    chk("t1_valid", 64'(cmd.cmd_valid), 64'(1));
    chk("t1_jdo", 64'(cmd.jdo), 64'(38'h2A_1234_5678));
    chk("t1_ir", 64'(cmd.cmd_ir), 64'(2));
    chk("t1_fill", 64'(fill), 64'(1));
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("t2_valid", 64'(cmd.cmd_valid), 64'(0));
    chk("t2_ta", 64'(cmd.take_action), 64'(4'b0100));
    chk("t2_tna", 64'(cmd.take_no_action), 64'(0));
    step();
    chk("t2_ta_end", 64'(cmd.take_action), 64'(0));
    repeat (4) step();
    chk("t2_held_no_repeat", 64'(fill), 64'(0));
    vs_udr = 1'b0;
    repeat (2) step();

    // Overfill: five commands into a four-deep FIFO, then drain
    for (int i = 0; i < 5; i++) udr_cmd(IR_W'(i % 4), (i % 2) == 0, 1'b0, 1'b0);
    chk("t3_fill", 64'(fill), 64'(4));
    chk("t3_ovf", 64'(overflow), 64'(1));
    cmd_ready = 1'b1;
    step();
    chk("t3_first_pulse", 64'(cmd.take_action), 64'(4'b0001));
    repeat (3) step();
    cmd_ready = 1'b0;
    step();

    // Full FIFO with a push coinciding with a pop
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 64'(overflow), 64'(0));
    for (int i = 0; i < 4; i++) udr_cmd(IR_W'(3 - i), $urandom_range(0, 1) == 1, 1'b0, 1'b0);
    udr_cmd(2'd1, 1'b1, 1'b1, 1'b0);
    chk("t4_fill", 64'(fill), 64'(4));
    chk("t4_ovf", 64'(overflow), 64'(0));
    cmd_ready = 1'b1;
    repeat (3) step();
    cmd_ready = 1'b0;
    chk("t4_last_ir", 64'(cmd.cmd_ir), 64'(1));
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();

    // IR update concurrent with a data update
    ir_in = 2'd3;
    sr = SR_W'({$urandom(), $urandom()});
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    repeat (S + 1) step();
    chk("t5_irup", 64'(ir_update), 64'(1));
    chk("t5_irl", 64'(ir_latched), 64'(3));
    chk("t5_fill", 64'(fill), 64'(1));
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    step();
    chk("t5_irup_end", 64'(ir_update), 64'(0));
    for (int i = 0; i < 3; i++) udr_cmd(IR_W'(i), 1'b0, 1'b0, 1'b0);
    udr_cmd(2'd0, 1'b1, 1'b0, 1'b1);
    chk("t5_set_wins", 64'(overflow), 64'(1));
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t5_clear", 64'(overflow), 64'(0));

    // Asynchronous reset mid-stream with a strobe in the synchroniser
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("t6_fill3", 64'(fill), 64'(3));
    vs_udr = 1'b1;
    step();
    vs_udr = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("t6_rst");
    repeat (2) step();
    reset_n = 1'b1;
    repeat (6) step();
    chk("t6_no_phantom", 64'(fill), 64'(0));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      vs_udr    = ($urandom_range(0, 3) == 0);
      vs_uir    = ($urandom_range(0, 5) == 0);
      ir_in     = IR_W'($urandom());
      sr        = SR_W'({$urandom(), $urandom()});
      cmd_ready = ($urandom_range(0, 2) == 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/debug_slave_cmd_bridge.md
Name: debug_slave_cmd_bridge

Overview:
Parametrised sysclk-domain command bridge for the Nios II JTAG debug slave. It synchronises the virtual-JTAG update strobes (vs_udr, vs_uir), captures the TCK-domain shift register and IR on each update, and queues commands in a FIFO of DEPTH entries. Commands are presented to the CPU debug logic through a valid/ready handshake, with one-hot take_action / take_no_action pulses per IR code. It replaces the fixed 2-bit-IR, 38-bit, unbuffered sysclk decoder.

Parameters:
IR_W, 2, IR width; NUM_CMD = 2**IR_W command codes
SR_W, 38, shift-register / command data width
ACT_BIT, 35, sr bit index selecting action (1) vs no-action (0); must be < SR_W
DEPTH, 4, command FIFO depth; power of two, >= 2
SYNC_STAGES, 2, synchroniser flops for vs_udr/vs_uir; >= 2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sr  in  SR_W  TCK-domain shift register, quasi-static around vs_udr
ir_in  in  IR_W  TCK-domain IR value, quasi-static around vs_udr/vs_uir
vs_udr  in  1  async update-DR level from virtual JTAG
vs_uir  in  1  async update-IR level from virtual JTAG
cmd_ready  in  1  consumer accepts head command
ovf_clr  in  1  clears sticky overflow
cmd_valid  out  1  FIFO non-empty
cmd_ir  out  IR_W  head command IR code
cmd_action  out  1  head command action flag
jdo  out  SR_W  head command data
take_action  out  NUM_CMD  one-hot registered pulse on pop, action=1
take_no_action  out  NUM_CMD  one-hot registered pulse on pop, action=0
ir_update  out  1  one-cycle pulse on synchronised vs_uir rising edge
ir_latched  out  IR_W  ir_in captured at ir_update
fill  out  log2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: push attempted while full

Behaviour:
- Reset (async assert, sync release by clk): all outputs 0, synchronisers 0, FIFO empty, fill=0; in-flight entries discarded.
- Synchroniser: vs_udr and vs_uir each pass through a SYNC_STAGES flop chain, then one edge-detect flop. Rising edge = last stage 1, edge flop 0.
- Push: on the clk edge where a udr rising edge is detected, write {ir_in, sr[ACT_BIT], sr} to tail. sr and ir_in are sampled directly at that edge (held stable by the TCK domain).
- Latency: vs_udr first sampled high at edge 1 -> push at edge SYNC_STAGES+1 -> cmd_valid=1 after that edge (3 cycles at default).
- Pop: on the edge where cmd_valid & cmd_ready. Head fields are registered FIFO outputs, valid whenever cmd_valid=1. cmd_ready with cmd_valid=0 has no effect.
- Pulses: on the edge after a pop, exactly one bit rises for one cycle: take_action[cmd_ir] if cmd_action=1, else take_no_action[cmd_ir]. Both buses 0 otherwise. Back-to-back pops give back-to-back pulses.
- Full: push while fill=DEPTH and no simultaneous pop -> command dropped, overflow<=1, FIFO unchanged.
- Simultaneous push+pop: when full, both proceed, fill unchanged, no overflow. When empty, push proceeds, pop is ignored, and the new entry becomes visible next cycle.
- overflow clears only on ovf_clr=1. If an overflow event coincides with ovf_clr, overflow stays 1 (set wins).
- vs_uir edge: ir_latched<=ir_in and ir_update=1 for one cycle, same latency as push. Independent of FIFO state. udr and uir edges in the same cycle are both honoured.
- Pointers wrap modulo DEPTH; fill counts 0..DEPTH.
- Strobe held high: exactly one push per rising edge, no repeat.

Test Plan:
- Reset, then vs_udr 0->1 with ir_in=2, sr[ACT_BIT]=1, sr=38'h2A_1234_5678, cmd_ready=0 -> cmd_valid rises after edge 3; jdo=38'h2A_1234_5678, cmd_ir=2, fill=1.
- Same state, assert cmd_ready one cycle -> cmd_valid=0 next edge; take_action=4'b0100 for exactly one cycle; take_no_action stays 0.
- Five udr pulses, ir=0..4 mod 4, action alternating, DEPTH=4, cmd_ready=0 -> fill=4, overflow=1, fifth dropped. Drain with cmd_ready=1 -> cmd_ir order 0,1,2,3; pulses alternate take_action/take_no_action on consecutive cycles.
- FIFO full, udr edge coincides with pop -> fill stays 4, overflow unchanged at 0; new entry is popped last.
- vs_uir pulse with ir_in=3, concurrent udr -> ir_update pulse, ir_latched=3, push also occurs. ovf_clr clears overflow only if no overflow event occurs in the same cycle.
- Assert reset_n=0 mid-stream with fill=3 and a strobe in the synchroniser -> all outputs 0 immediately. After release, no phantom push or pulse.
